// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - fetch-side and EX-side handshake bundle of the queued ID stage
// ex_illegal exists only when ID_ILLEGAL_DET_EN is defined.
interface id_stage_pipe_if #(
    parameter int PC_WIDTH = 10
);
    logic                if_valid;
    logic                if_ready;
    logic [PC_WIDTH-1:0] if_pc;
    logic [31:0]         if_inst;

    logic                ex_valid;
    logic                ex_ready;
    logic [PC_WIDTH-1:0] ex_pc;
    logic [6:0]          ex_opcode;
    logic [2:0]          ex_funct3;
    logic [6:0]          ex_funct7;
    logic [31:0]         ex_imm;
    logic [31:0]         ex_rs1_data;
    logic [31:0]         ex_rs2_data;
    logic [4:0]          ex_rs1_addr;
    logic [4:0]          ex_rs2_addr;
    logic                ex_rd_we;
    logic [4:0]          ex_rd_addr;
`ifdef ID_ILLEGAL_DET_EN
    logic                ex_illegal;
`endif

    modport master (
        input  if_valid, if_pc, if_inst, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_we, ex_rd_addr
`ifdef ID_ILLEGAL_DET_EN
        , output ex_illegal
`endif
    );

    modport slave (
        output if_valid, if_pc, if_inst, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_we, ex_rd_addr
`ifdef ID_ILLEGAL_DET_EN
        , input ex_illegal
`endif
    );
endinterface

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - queued RV32I decode stage with load-use stall and valid/ready ID/EX register
// Define ID_ILLEGAL_DET_EN to add ex_illegal and squash enables of illegal instructions.
module id_stage_pipe #(
    parameter int PC_WIDTH = 10,
    parameter int IQ_DEPTH = 4,
    parameter int CNT_W    = $clog2(IQ_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_pipe_if.master      bus,
    input  logic                 flush,
    output logic                 rs1_re,
    output logic [4:0]           rs1_addr,
    input  logic [31:0]          rs1_data_i,
    output logic                 rs2_re,
    output logic [4:0]           rs2_addr,
    input  logic [31:0]          rs2_data_i,
    output logic [CNT_W-1:0]     iq_count
);
    localparam int PTR_W = $clog2(IQ_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [PC_WIDTH-1:0] iq_pc_q   [IQ_DEPTH];
    logic [31:0]         iq_inst_q [IQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                full, head_valid, push, pop, advance, hazard;
    logic [31:0]         head_inst;
    logic [PC_WIDTH-1:0] head_pc;
    logic                dec_rs1_re, dec_rs2_re, dec_rd_we, dec_illegal;
    logic [31:0]         dec_imm;
    logic                rd_we;
    logic [4:0]          rd_addr;

    logic                ex_valid_q;
    logic [PC_WIDTH-1:0] ex_pc_q;
    logic [6:0]          ex_opcode_q, ex_funct7_q;
    logic [2:0]          ex_funct3_q;
    logic [31:0]         ex_imm_q, ex_rs1_data_q, ex_rs2_data_q;
    logic [4:0]          ex_rs1_addr_q, ex_rs2_addr_q, ex_rd_addr_q;
    logic                ex_rd_we_q;

    assign full       = (count_q == CNT_W'(IQ_DEPTH));
    assign head_valid = (count_q != '0);
    assign head_inst  = iq_inst_q[rd_ptr_q];
    assign head_pc    = iq_pc_q[rd_ptr_q];

    // if_ready deliberately ignores a same-cycle pop to keep it off the hazard path
    assign push    = bus.if_valid && !full && !flush;
    assign advance = !ex_valid_q || bus.ex_ready;
    assign pop     = head_valid && advance && !hazard && !flush;

    always_comb begin
        dec_rs1_re = 1'b0;
        dec_rs2_re = 1'b0;
        dec_rd_we  = 1'b0;
        dec_imm    = '0;
        case (head_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_imm   = {head_inst[31:12], 12'b0};
                dec_rd_we = 1'b1;
            end
            OPC_JAL: begin
                dec_imm   = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                             head_inst[20], head_inst[30:21], 1'b0};
                dec_rd_we = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                dec_imm    = {{20{head_inst[31]}}, head_inst[31:20]};
                dec_rs1_re = 1'b1;
                dec_rd_we  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm    = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                              head_inst[30:25], head_inst[11:8], 1'b0};
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
            end
            OPC_STORE: begin
                dec_imm    = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
            end
            OPC_OPIMM: begin
                // shift-immediates carry shamt only; funct7 bits must not leak into imm
                if (head_inst[14:12] == 3'b001 || head_inst[14:12] == 3'b101)
                    dec_imm = {27'b0, head_inst[24:20]};
                else
                    dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
                dec_rs1_re = 1'b1;
                dec_rd_we  = 1'b1;
            end
            OPC_OP: begin
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
                dec_rd_we  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ID_ILLEGAL_DET_EN
    always_comb begin
        dec_illegal = 1'b0;
        case (head_inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
        if (head_inst[1:0] != 2'b11)
            dec_illegal = 1'b1;
        if ((head_inst[6:0] == OPC_OP ||
             (head_inst[6:0] == OPC_OPIMM && head_inst[14:12] == 3'b101)) &&
            head_inst[31:25] != 7'b0000000 && head_inst[31:25] != 7'b0100000)
            dec_illegal = 1'b1;
    end
`else
    assign dec_illegal = 1'b0;
`endif

    assign rs1_re   = head_valid && dec_rs1_re && !dec_illegal;
    assign rs2_re   = head_valid && dec_rs2_re && !dec_illegal;
    assign rd_we    = head_valid && dec_rd_we && !dec_illegal;
    assign rs1_addr = rs1_re ? head_inst[19:15] : 5'd0;
    assign rs2_addr = rs2_re ? head_inst[24:20] : 5'd0;
    assign rd_addr  = rd_we ? head_inst[11:7] : 5'd0;

    assign hazard = ex_valid_q && (ex_opcode_q == OPC_LOAD) && ex_rd_we_q && (ex_rd_addr_q != 5'd0) &&
                    ((rs1_re && rs1_addr == ex_rd_addr_q) || (rs2_re && rs2_addr == ex_rd_addr_q));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            iq_pc_q[wr_ptr_q]   <= bus.if_pc;
            iq_inst_q[wr_ptr_q] <= bus.if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_opcode_q   <= '0;
            ex_funct3_q   <= '0;
            ex_funct7_q   <= '0;
            ex_imm_q      <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_rs1_addr_q <= '0;
            ex_rs2_addr_q <= '0;
            ex_rd_we_q    <= 1'b0;
            ex_rd_addr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (flush) begin
                ex_valid_q <= 1'b0;
            end else if (pop) begin
                ex_valid_q    <= 1'b1;
                ex_pc_q       <= head_pc;
                ex_opcode_q   <= head_inst[6:0];
                ex_funct3_q   <= head_inst[14:12];
                ex_funct7_q   <= head_inst[31:25];
                ex_imm_q      <= dec_imm;
                ex_rs1_data_q <= rs1_data_i;
                ex_rs2_data_q <= rs2_data_i;
                ex_rs1_addr_q <= rs1_addr;
                ex_rs2_addr_q <= rs2_addr;
                ex_rd_we_q    <= rd_we;
                ex_rd_addr_q  <= rd_addr;
            end else if (advance) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

`ifdef ID_ILLEGAL_DET_EN
    logic ex_illegal_q;

    always_ff @(posedge clk) begin
        if (rst)
            ex_illegal_q <= 1'b0;
        else if (!flush && pop)
            ex_illegal_q <= dec_illegal;
    end

    assign bus.ex_illegal = ex_illegal_q;
`endif

    assign bus.if_ready    = !full;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_funct7   = ex_funct7_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_rs1_addr = ex_rs1_addr_q;
    assign bus.ex_rs2_addr = ex_rs2_addr_q;
    assign bus.ex_rd_we    = ex_rd_we_q;
    assign bus.ex_rd_addr  = ex_rd_addr_q;
    assign iq_count        = count_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - randomized bench for id_stage_pipe against a queue-based reference model
// Honours ID_ILLEGAL_DET_EN the same way as the design.
module tb_id_stage_pipe;
    localparam int PC_WIDTH = 10;
    localparam int IQ_DEPTH = 4;
    localparam int CNT_W    = $clog2(IQ_DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic rs1_re, rs2_re;
    logic [4:0] rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [CNT_W-1:0] iq_count;

    id_stage_pipe_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    id_stage_pipe #(.PC_WIDTH(PC_WIDTH), .IQ_DEPTH(IQ_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .rs1_re(rs1_re), .rs1_addr(rs1_addr), .rs1_data_i(rs1_data),
        .rs2_re(rs2_re), .rs2_addr(rs2_addr), .rs2_data_i(rs2_data),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf1(input logic [4:0] a);
        return 32'h1000_0000 + 32'(a) * 32'h0001_0001;
    endfunction
    function automatic logic [31:0] rf2(input logic [4:0] a);
        return 32'hA5A5_0000 ^ (32'(a) << 3);
    endfunction

    assign rs1_data = rf1(rs1_addr);
    assign rs2_data = rf2(rs2_addr);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
    } ent_t;

    typedef struct packed {
        logic        r1e, r2e, we, ill;
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm;
    } dec_t;

    ent_t q[$];
    logic m_valid = 1'b0;
    ent_t m_ex = '0;
    logic [PC_WIDTH-1:0] pc_cnt = 10'h004;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode: immediates by arithmetic shifts of re-packed fields
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        logic [6:0] op;
        logic [31:0] t;
        d = '0;
        op = w[6:0];
        t = {w[31:25], w[11:7], 20'b0};
        if (op == 7'h37 || op == 7'h17) begin
            d.imm = w & 32'hFFFF_F000; d.we = 1;
        end else if (op == 7'h6F) begin
            t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0};
            d.imm = $signed(t) >>> 11; d.we = 1;
        end else if (op == 7'h67 || op == 7'h03) begin
            d.imm = $signed(w) >>> 20; d.r1e = 1; d.we = 1;
        end else if (op == 7'h63) begin
            t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};
            d.imm = $signed(t) >>> 19; d.r1e = 1; d.r2e = 1;
        end else if (op == 7'h23) begin
            d.imm = $signed(t) >>> 20; d.r1e = 1; d.r2e = 1;
        end else if (op == 7'h13) begin
            d.imm = (w[13:12] == 2'b01) ? 32'(w[24:20]) : 32'($signed(w) >>> 20);
            d.r1e = 1; d.we = 1;
        end else if (op == 7'h33) begin
            d.r1e = 1; d.r2e = 1; d.we = 1;
        end
`ifdef ID_ILLEGAL_DET_EN
        d.ill = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73}) ||
                (w[1:0] != 2'b11) ||
                ((op == 7'h33 || (op == 7'h13 && w[14:12] == 3'b101)) && !(w[31:25] inside {7'h00, 7'h20}));
        if (d.ill) begin
            d.r1e = 0; d.r2e = 0; d.we = 0;
        end
`endif
        d.r1 = d.r1e ? w[19:15] : 5'd0;
        d.r2 = d.r2e ? w[24:20] : 5'd0;
        d.rd = d.we ? w[11:7] : 5'd0;
        return d;
    endfunction

    function automatic dec_t head_dec();
        if (q.size() == 0) return '0;
        return ref_decode(q[0].inst);
    endfunction

    task automatic check_state();
        dec_t d;
        check_eq("ex_valid", bus.ex_valid, m_valid);
        check_eq("iq_count", 32'(iq_count), 32'(q.size()));
        if (m_valid) begin
            d = ref_decode(m_ex.inst);
            check_eq("ex_pc", 32'(bus.ex_pc), 32'(m_ex.pc));
            check_eq("ex_opcode", 32'(bus.ex_opcode), 32'(m_ex.inst[6:0]));
            check_eq("ex_funct3", 32'(bus.ex_funct3), 32'(m_ex.inst[14:12]));
            check_eq("ex_funct7", 32'(bus.ex_funct7), 32'(m_ex.inst[31:25]));
            check_eq("ex_imm", bus.ex_imm, d.imm);
            check_eq("ex_rs1_addr", 32'(bus.ex_rs1_addr), 32'(d.r1));
            check_eq("ex_rs2_addr", 32'(bus.ex_rs2_addr), 32'(d.r2));
            check_eq("ex_rs1_data", bus.ex_rs1_data, rf1(d.r1));
            check_eq("ex_rs2_data", bus.ex_rs2_data, rf2(d.r2));
            check_eq("ex_rd_we", 32'(bus.ex_rd_we), 32'(d.we));
            check_eq("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(d.rd));
`ifdef ID_ILLEGAL_DET_EN
            check_eq("ex_illegal", 32'(bus.ex_illegal), 32'(d.ill));
`endif
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        dec_t dh, dx;
        logic hz, adv, pop, push;
        ent_t e;
        @(negedge clk);
        rst = 0;
        bus.if_valid = v; bus.if_inst = w; bus.if_pc = pc_cnt; bus.ex_ready = rdy; flush = fl;
        #1;
        dh = head_dec();
        check_eq("if_ready", 32'(bus.if_ready), 32'(q.size() < IQ_DEPTH));
        check_eq("rs1_re", 32'(rs1_re), 32'(dh.r1e));
        check_eq("rs1_addr", 32'(rs1_addr), 32'(dh.r1));
        check_eq("rs2_re", 32'(rs2_re), 32'(dh.r2e));
        check_eq("rs2_addr", 32'(rs2_addr), 32'(dh.r2));
        dx = ref_decode(m_ex.inst);
        hz = m_valid && m_ex.inst[6:0] == 7'h03 && dx.we && dx.rd != 0 &&
             ((dh.r1e && dh.r1 == dx.rd) || (dh.r2e && dh.r2 == dx.rd));
        adv = !m_valid || rdy;
        pop = (q.size() > 0) && adv && !hz && !fl;
        push = v && (q.size() < IQ_DEPTH) && !fl;
        if (fl) begin
            q.delete();
            m_valid = 0;
        end else begin
            if (pop) begin
                m_ex = q.pop_front();
                m_valid = 1;
            end else if (adv) begin
                m_valid = 0;
            end
            if (push) begin
                e.pc = pc_cnt; e.inst = w;
                q.push_back(e);
                pc_cnt += 10'd4;
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset(input logic v, input logic rdy, input logic fl);
        @(negedge clk);
        rst = 1; bus.if_valid = v; bus.if_inst = $urandom; bus.if_pc = pc_cnt;
        bus.ex_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
        q.delete();
        m_valid = 0;
        check_eq("rst_ex_valid", 32'(bus.ex_valid), 0);
        check_eq("rst_ex_pc", 32'(bus.ex_pc), 0);
        check_eq("rst_ex_fields", {bus.ex_opcode, bus.ex_funct3, bus.ex_funct7, bus.ex_rd_we,
                                   bus.ex_rd_addr, bus.ex_rs1_addr, bus.ex_rs2_addr}, 0);
        check_eq("rst_ex_imm", bus.ex_imm, 0);
        check_eq("rst_ex_rs1_data", bus.ex_rs1_data, 0);
        check_eq("rst_ex_rs2_data", bus.ex_rs2_data, 0);
        check_eq("rst_iq_count", 32'(iq_count), 0);
        check_eq("rst_if_ready", 32'(bus.if_ready), 1);
`ifdef ID_ILLEGAL_DET_EN
        check_eq("rst_ex_illegal", 32'(bus.ex_illegal), 0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 7; i++) cycle(0, 32'h0, 1, 0);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 13);
        case (k)
            0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5, 6: r[6:0] = 7'h03;
            7: r[6:0] = 7'h23;  8: r[6:0] = 7'h13;  10: r[6:0] = 7'h0F;
            11: r[6:0] = 7'h73; 12: r[6:0] = 7'h33;
            9: begin
                r[6:0] = 7'h13;
                r[14:12] = $urandom_range(0, 1) ? 3'b001 : 3'b101;
                if ($urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            default: ;
        endcase
        if (k == 12 && $urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        bus.if_valid = 0; bus.if_inst = 0; bus.if_pc = 0; bus.ex_ready = 1;
        do_reset(0, 1, 0);
        do_reset(1, 0, 1);

        // ADDI x1,x0,-1 at pc 0x004
        cycle(1, 32'hFFF0_0093, 1, 0);
        cycle(0, 32'h0, 1, 0);
        check_eq("addi_valid", 32'(bus.ex_valid), 1);
        check_eq("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);
        check_eq("addi_rd", 32'(bus.ex_rd_addr), 1);
        check_eq("addi_rs1", 32'(bus.ex_rs1_addr), 0);
        check_eq("addi_pc", 32'(bus.ex_pc), 32'h004);

        // load-use on rs1, then on rs2
        for (int c = 0; c < 2; c++) begin
            cycle(1, 32'h0001_2283, 1, 0);
            cycle(1, (c == 0) ? 32'h0032_8333 : 32'h0051_8333, 1, 0);
            check_eq("lw_issued", 32'(bus.ex_opcode), 32'h03);
            cycle(0, 32'h0, 1, 0);
            check_eq("lu_bubble", 32'(bus.ex_valid), 0);
            cycle(0, 32'h0, 1, 0);
            check_eq("lu_add_valid", 32'(bus.ex_valid), 1);
            check_eq("lu_add_opcode", 32'(bus.ex_opcode), 32'h33);
        end
        drain();

        // SW x7,-4(x8)
        cycle(1, 32'hFE74_2E23, 1, 0);
        cycle(0, 32'h0, 1, 0);
        check_eq("sw_imm", bus.ex_imm, 32'hFFFF_FFFC);
        check_eq("sw_rs1", 32'(bus.ex_rs1_addr), 8);
        check_eq("sw_rs2", 32'(bus.ex_rs2_addr), 7);
        check_eq("sw_rd_we", 32'(bus.ex_rd_we), 0);
        check_eq("sw_rd_addr", 32'(bus.ex_rd_addr), 0);

        // SLLI x1,x1,3 and the all-zero word
        cycle(1, 32'h0030_9093, 1, 0);
        cycle(1, 32'h0000_0000, 1, 0);
        check_eq("slli_imm", bus.ex_imm, 3);
`ifdef ID_ILLEGAL_DET_EN
        check_eq("slli_legal", 32'(bus.ex_illegal), 0);
`endif
        cycle(0, 32'h0, 1, 0);
        check_eq("zero_rd_we", 32'(bus.ex_rd_we), 0);
`ifdef ID_ILLEGAL_DET_EN
        check_eq("zero_illegal", 32'(bus.ex_illegal), 1);
`endif
        drain();

        // EX stalled while fetch keeps pushing
        cycle(1, 32'h0000_0093, 1, 0);
        for (int k = 1; k <= 5; k++)
            cycle(1, (32'(k) << 20) | (32'(k) << 7) | 32'h13, 0, 0);
        check_eq("stall_full_count", 32'(iq_count), IQ_DEPTH);
        check_eq("stall_if_ready", 32'(bus.if_ready), 0);
        for (int k = 0; k < 6; k++) cycle(0, 32'h0, 1, 0);

        // flush with three queued, one in EX, and a push offered
        for (int k = 1; k <= 4; k++)
            cycle(1, (32'(k) << 20) | (32'(k + 8) << 7) | 32'h13, 0, 0);
        check_eq("pre_flush_count", 32'(iq_count), 3);
        cycle(1, 32'h0070_0393, 1, 1);
        check_eq("flush_count", 32'(iq_count), 0);
        check_eq("flush_valid", 32'(bus.ex_valid), 0);
        for (int k = 0; k < 3; k++) cycle(0, 32'h0, 1, 0);

        // random traffic with a mid-run reset
        for (int i = 0; i < 500; i++) begin
            if (i == 250)
                do_reset(1, 0, 1);
            else
                cycle($urandom_range(0, 9) < 7, gen_inst(), $urandom_range(0, 9) < 7,
                      $urandom_range(0, 39) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
